// File: rtl/spi_master_xfer_ctrl.sv
// spi_master_xfer_ctrl: single-word SPI master transfer sequencer.
// Accepts a word over valid/ready, then runs chip select, sclk and mosi0
// through the SETUP, XFER and HOLD phases. The received word comes back as a
// one-cycle rsp_valid pulse.
// Build option: SPI_LOOPBACK_EN makes the receive shifter sample the internal
// mosi0 register instead of miso0, so rsp_data echoes the transmitted word.
module spi_master_xfer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 8,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [CS_W-1:0]       req_cs,
    input  logic                  req_cpol,
    input  logic                  req_cpha,
    input  logic [DIV_WIDTH-1:0]  req_div,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic                  sclk,
    output logic [NUM_CS-1:0]     cs,
    output logic                  mosi0,
    input  logic                  miso0
);

    localparam int HP_W = $clog2(2 * DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                state;
    // One bit wider than the divider so H = div+1 always fits.
    logic [DIV_WIDTH:0]    cnt;
    logic [HP_W-1:0]       hp;
    logic [DIV_WIDTH-1:0]  div_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;

    logic                  phase_done;
    logic                  last_hp;
    logic                  edge_now;
    logic                  edge_lead;
    logic                  shift_now;
    logic                  sample_now;
    logic                  rx_bit;
    logic [NUM_CS-1:0]     cs_sel;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = mosi0;
`else
    assign rx_bit = miso0;
`endif

    // Edge bookkeeping: the end of a half-period in SETUP or XFER (except the
    // final one) is an sclk edge. SETUP ends on a leading edge; afterwards
    // the next edge is leading when the current half-period index is odd.
    always_comb begin
        phase_done = (cnt == {1'b0, div_q});
        last_hp    = (hp == HP_W'(2 * DATA_WIDTH - 1));
        edge_now   = phase_done && ((state == SETUP) || ((state == XFER) && !last_hp));
        edge_lead  = (state == SETUP) || hp[0];
        shift_now  = edge_now && (edge_lead == cpha_q);
        sample_now = edge_now && (edge_lead != cpha_q);
    end

    // Chip-select decode; an out-of-range index leaves every line high.
    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (req_cs == CS_W'(i)) cs_sel[i] = 1'b0;
        end
    end

    // Transfer FSM with registered bus and response outputs.
    always_ff @(posedge pclk) begin
        if (areset) begin
            state     <= IDLE;
            cnt       <= '0;
            hp        <= '0;
            div_q     <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sclk      <= 1'b0;
            cs        <= '1;
            mosi0     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (shift_now) begin
                mosi0 <= tx_sr[DATA_WIDTH-1];
                tx_sr <= tx_sr << 1;
            end
            if (sample_now) rx_sr <= {rx_sr[DATA_WIDTH-2:0], rx_bit};

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        div_q  <= req_div;
                        cpol_q <= req_cpol;
                        cpha_q <= req_cpha;
                        cs     <= cs_sel;
                        sclk   <= req_cpol;
                        cnt    <= '0;
                        // cpha=0 puts the MSB out during SETUP; cpha=1 waits
                        // for the first leading edge to shift it out.
                        if (req_cpha) begin
                            tx_sr <= req_data;
                        end else begin
                            tx_sr <= req_data << 1;
                            mosi0 <= req_data[DATA_WIDTH-1];
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        cnt   <= '0;
                        hp    <= '0;
                        sclk  <= ~cpol_q;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (phase_done) begin
                        cnt <= '0;
                        if (last_hp) begin
                            sclk  <= cpol_q;
                            state <= HOLD;
                        end else begin
                            hp   <= hp + 1'b1;
                            sclk <= ~sclk;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        cnt       <= '0;
                        cs        <= '1;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rx_sr;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// Testbench for spi_master_xfer_ctrl: randomized requests against a
// behavioural SPI slave/bus monitor and a response scoreboard.
// Honours SPI_LOOPBACK_EN (miso0 tied low, response equals sent word).
module tb_spi_master_xfer_ctrl;

    localparam int DW  = 8;
    localparam int NCS = 4;
    localparam int DVW = 8;

    logic           pclk = 1'b0;
    logic           areset;
    logic           req_valid;
    logic           req_ready;
    logic [DW-1:0]  req_data;
    logic [1:0]     req_cs;
    logic           req_cpol;
    logic           req_cpha;
    logic [DVW-1:0] req_div;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_data;
    logic           busy;
    logic           sclk;
    logic [NCS-1:0] cs;
    logic           mosi0;
    logic           miso0;
    logic           smiso = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] sw;
        int            cs_idx;
        bit            cpol;
        bit            cpha;
        int            h;
    } xfer_t;

    xfer_t         bus_q[$];
    logic [DW-1:0] rsp_q[$];

    always #5 pclk = ~pclk;

`ifdef SPI_LOOPBACK_EN
    assign miso0 = 1'b0;
`else
    assign miso0 = smiso;
`endif

    spi_master_xfer_ctrl #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DVW)) dut (
        .pclk(pclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_cs(req_cs), .req_cpol(req_cpol), .req_cpha(req_cpha), .req_div(req_div),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor + slave model + response scoreboard, all on the falling edge.
    xfer_t         cur;
    bit            active = 0;
    logic [NCS-1:0] prev_cs = '1;
    logic          prev_sclk = 1'b0;
    int            lowcnt, run, edges, ptr;
    int            gap_cnt = 0;
    int            last_gap = 0;
    logic [DW-1:0] mrx;

    always @(negedge pclk) begin
        if (areset) begin
            bus_q.delete();
            rsp_q.delete();
            active    = 0;
            prev_cs   = '1;
            prev_sclk = sclk;
            gap_cnt   = 0;
        end else begin
            if (cs != '1 && prev_cs == '1) begin
                last_gap = gap_cnt;
                gap_cnt  = 0;
                if (bus_q.size() == 0) begin
                    chk("unexpected_cs_fall", 1, 0);
                end else begin
                    logic [NCS-1:0] ecs;
                    cur    = bus_q.pop_front();
                    active = 1;
                    lowcnt = 1;
                    run    = 0;
                    edges  = 0;
                    mrx    = '0;
                    ecs    = '1;
                    if (cur.cs_idx < NCS) ecs[cur.cs_idx] = 1'b0;
                    chk("cs_pattern", cs, ecs);
                    chk("setup_sclk", sclk, cur.cpol);
                    if (!cur.cpha) begin
                        smiso = cur.sw[DW-1];
                        ptr   = DW - 2;
                    end else begin
                        ptr = DW - 1;
                    end
                end
            end else if (active && cs != '1) begin
                lowcnt++;
                run++;
                if (sclk != prev_sclk) begin
                    chk("half_period", run, cur.h);
                    run = 0;
                    edges++;
                    // Sample on leading edge for cpha=0, trailing for cpha=1;
                    // drive the next slave bit on the other edge.
                    if ((sclk != cur.cpol) != cur.cpha) begin
                        mrx = {mrx[DW-2:0], mosi0};
                    end else if (ptr >= 0) begin
                        smiso = cur.sw[ptr];
                        ptr--;
                    end
                end
            end else if (active && cs == '1) begin
                active = 0;
                chk("cs_low_len", lowcnt, cur.h * (2 * DW + 2));
                chk("sclk_edges", edges, 2 * DW);
                chk("mosi_word", mrx, cur.data);
                chk("idle_sclk", sclk, cur.cpol);
            end
            if (cs == '1) gap_cnt++;
            if (rsp_valid) begin
                chk("rsp_first_cs_high", (prev_cs != '1) && (cs == '1), 1);
                if (rsp_q.size() == 0) chk("unexpected_rsp", 1, 0);
                else chk("rsp_data", rsp_data, rsp_q.pop_front());
            end
            prev_cs   = cs;
            prev_sclk = sclk;
        end
    end

    task automatic send(input logic [DW-1:0] d, input int csi, input bit pol,
                        input bit pha, input int dv, input logic [DW-1:0] sw);
        xfer_t x;
        int    n = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_cs    = 2'(csi);
        req_cpol  = pol;
        req_cpha  = pha;
        req_div   = DVW'(dv);
        while (!req_ready && n < 20000) begin
            @(posedge pclk); #1;
            n++;
        end
        if (n >= 20000) chk("accept_timeout", n, 0);
        x.data = d; x.sw = sw; x.cs_idx = csi; x.cpol = pol; x.cpha = pha; x.h = dv + 1;
        bus_q.push_back(x);
`ifdef SPI_LOOPBACK_EN
        rsp_q.push_back(d);
`else
        rsp_q.push_back(sw);
`endif
        @(posedge pclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || !req_ready) && n < 20000) begin
            @(posedge pclk); #1;
            n++;
        end
        if (n >= 20000) chk("drain_timeout", n, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        // Requests during reset must be ignored.
        areset = 1'b1; req_valid = 1'b1; req_data = 8'hFF; req_cs = 2'd1;
        req_cpol = 1'b1; req_cpha = 1'b1; req_div = '0;
        repeat (3) @(posedge pclk);
        #1 areset = 1'b0; req_valid = 1'b0;
        @(negedge pclk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cs", cs, 4'hF);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi0, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(posedge pclk); #1;
        chk("no_accept_in_reset", cs, 4'hF);

        // Directed cases.
        send(8'hA5, 0, 0, 0, 0, 8'h3C); drain();
        send(8'h81, 2, 1, 1, 3, 8'hFF); drain();
        send(8'h96, 1, 0, 1, 1, 8'h5A); drain();
        send(8'h11, 3, 0, 0, 0, 8'hE7);
        send(8'h22, 3, 0, 0, 0, 8'h18); drain();
        chk("b2b_gap", last_gap, 1);
        send(8'hC3, 1, 1, 0, 0, DW'($urandom)); drain();

        // Reset in cycle 7 of a transfer.
        send(8'h5A, 1, 0, 0, 0, DW'($urandom));
        repeat (6) begin @(posedge pclk); #1; end
        areset = 1'b1;
        @(posedge pclk); #1;
        areset = 1'b0;
        chk("midrst_cs", cs, 4'hF);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        send(8'h3C, 0, 0, 0, 0, 8'hC3); drain();

        // Maximum divider.
        send(DW'($urandom), 2, 1, 0, 255, DW'($urandom)); drain();

        // Randomized traffic, sometimes back-to-back.
        for (int i = 0; i < 24; i++) begin
            send(DW'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3), DW'($urandom));
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_master_xfer_ctrl.md
# spi_master_xfer_ctrl

SPI master transfer controller that sequences single-word transactions onto the SPI bus used by the slave agent environment. It accepts a word request over a valid/ready handshake and latches the mode (CPOL/CPHA) and clock divider at accept. It drives chip-select, serial clock and MOSI, samples MISO, and returns the received word as a one-cycle response pulse. It is the DUT-side bus owner that the slave BFM responds to.

## Interface

Parameters:
- DATA_WIDTH, 8, bits per transfer, MSB first; legal range 2 to 32.
- NUM_CS, 4, number of active-low chip-select lines.
- DIV_WIDTH, 8, width of the clock-divider input.

Ports:
- pclk  in  1  system clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request.
- req_ready  out  1  high while the controller is idle (state IDLE).
- req_data  in  DATA_WIDTH  word to shift out.
- req_cs  in  2  index of the chip select to assert (clog2 NUM_CS).
- req_cpol  in  1  sclk idle level.
- req_cpha  in  1  0 means sample on the leading edge; 1 means sample on the trailing edge.
- req_div  in  DIV_WIDTH  sclk half period is H = req_div + 1 pclk cycles.
- rsp_valid  out  1  one-cycle pulse at end of transfer.
- rsp_data  out  DATA_WIDTH  received word, held until the next rsp_valid.
- busy  out  1  inverse of req_ready.
- sclk  out  1  SPI serial clock.
- cs  out  NUM_CS  chip selects, active low.
- mosi0  out  1  master out.
- miso0  in  1  master in.

## Operation

- FSM states: IDLE, SETUP, XFER, HOLD.
- IDLE:
  - req_ready=1.
  - Accept occurs on req_valid && req_ready.
  - On accept, latch req_data, req_cs, req_cpol, req_cpha and req_div, then go to SETUP.
  - Changes to the request inputs after accept have no effect on the transfer in progress.
- SETUP lasts H cycles:
  - cs[req_cs]=0 and sclk=cpol.
  - If cpha=0, mosi0 presents the MSB from the first SETUP cycle.
- XFER consists of 2*DATA_WIDTH half-periods of H cycles each; sclk toggles at every half-period boundary.
  - cpha=0: sample miso0 on the leading edge, shift mosi0 on the trailing edge.
  - cpha=1: shift mosi0 on the leading edge (MSB on the first one), sample on the trailing edge.
  - Received bits shift in at the LSB.
- HOLD lasts H cycles: sclk=cpol, cs is still asserted.
- End of HOLD:
  - Go to IDLE and deassert all cs.
  - rsp_valid=1 for one cycle and rsp_data is updated in that same cycle.
- Out-of-range req_cs (>= NUM_CS): the transfer runs with no cs asserted, and rsp_data holds whatever was sampled.
- In IDLE, sclk holds the latched cpol of the last transfer.

## Timing

- Reset values: state IDLE, req_ready=1, busy=0, cs all ones, sclk=0, mosi0=0, rsp_valid=0, rsp_data=0, latched cpol/cpha/div=0.
- Requests presented while areset=1 are not accepted.
- cs is low for exactly H*(2*DATA_WIDTH+2) pclk cycles, starting the cycle after accept.
- rsp_valid asserts in the first cycle cs is high again.
- Example: DATA_WIDTH=8 and H=1 gives 18 cycles low, with rsp_valid on cycle 19 after accept.
- Back-to-back:
  - A request may be accepted in the rsp_valid cycle.
  - cs is then high for exactly one pclk cycle between transfers; this is the minimum gap.
- Reset mid-transfer:
  - Outputs take their reset values on the next cycle.
  - No rsp_valid is produced and the partial word is discarded.
- The half-period counter is DIV_WIDTH+1 bits wide and never wraps within a transfer; req_div at its maximum is legal.

## Configuration

- SPI_LOOPBACK_EN defined:
  - The receive shifter samples the internal mosi0 register instead of miso0.
  - rsp_data equals the transmitted word for every mode.
  - miso0 is ignored.
- SPI_LOOPBACK_EN undefined: the receive shifter samples miso0 as specified above.

## Test plan

- Mode 0, req_div=0, req_data=0xA5, slave returns 0x3C:
  - mosi0 at rising sclk edges reads 1,0,1,0,0,1,0,1.
  - rsp_data=0x3C, cs[0] low for 18 cycles, rsp_valid on cycle 19.
- Mode 3, req_div=3, req_cs=2, req_data=0x81, slave returns 0xFF:
  - sclk idles high with a half period of 4 cycles.
  - Only cs[2] is low, for 72 cycles; rsp_data=0xFF.
- Mode 1, req_div=1, slave returns 0x5A: sampling happens on falling sclk edges and rsp_data=0x5A.
- Two back-to-back requests, with req_valid held high and data 0x11 then 0x22:
  - Two rsp_valid pulses occur, with a 1-cycle cs-high gap.
  - mosi0 carries 0x11 then 0x22.
- Assert areset for one cycle at cycle 7 of a transfer:
  - cs goes all ones and rsp_valid=0 on the next cycle.
  - req_ready=1, and a following 0x3C transfer completes normally.
- With SPI_LOOPBACK_EN and miso0 tied to 0, req_data=0xC3 in mode 2: rsp_data=0xC3.
